// File: rtl/npc_pkg.sv
// Shared types and constants for the next-address generator.
package npc_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        HOLD      = 2'b01,
        HOLD_PEND = 2'b10
    } npc_state_t;

    localparam logic [1:0]  CAUSE_NONE     = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_ZERO     = 2'b10;
    localparam logic [1:0]  CAUSE_WRAP     = 2'b11;

    // pc ignores a zero next_addr, so zero doubles as the hold encoding.
    localparam logic [31:0] HOLD_ADDR      = 32'h0;

endpackage

// File: rtl/next_pc_target_check.sv
// Combinational legality check for a redirect destination.
module target_check
    import npc_pkg::*;
(
    input  logic [31:0] target,
    output logic        ok,
    output logic [1:0]  cause
);

    always_comb begin
        ok    = 1'b1;
        cause = CAUSE_NONE;
        if (target[1:0] != 2'b00) begin
            ok    = 1'b0;
            cause = CAUSE_MISALIGN;
        end else if (target == HOLD_ADDR) begin
            ok    = 1'b0;
            cause = CAUSE_ZERO;
        end
    end

endmodule

// File: rtl/next_pc.sv
// Next-address generator feeding pc: sequential, redirect, stall, trap and mret.
module next_pc
    import npc_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cur_addr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_req,
    input  logic        mret_req,
    output logic [31:0] next_addr,
    output logic [31:0] epc,
    output logic        pend_valid,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    npc_state_t  r_state;
    logic [31:0] r_next_addr;
    logic [31:0] r_epc;
    logic [31:0] r_pend_target;
    logic        r_fault;
    logic [1:0]  r_fault_cause;

    logic        w_redir_ok;
    logic [1:0]  w_redir_cause;
    logic        w_pend_ok;
    logic [1:0]  w_pend_cause;
    logic [31:0] w_seq_addr;
    logic        w_wrap;

    target_check u_redir_check (
        .target (redirect_target),
        .ok     (w_redir_ok),
        .cause  (w_redir_cause)
    );

    target_check u_pend_check (
        .target (r_pend_target),
        .ok     (w_pend_ok),
        .cause  (w_pend_cause)
    );

    assign w_seq_addr = cur_addr + 32'd4;
    assign w_wrap     = (w_seq_addr == 32'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_next_addr   <= HOLD_ADDR;
            r_epc         <= '0;
            r_pend_target <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= CAUSE_NONE;
        end else begin
            r_fault <= 1'b0;
            if (trap_req) begin
                r_next_addr <= TRAP_VEC;
                r_epc       <= cur_addr;
                r_state     <= RUN;
            end else if (mret_req) begin
                r_next_addr <= r_epc;
                r_state     <= RUN;
            end else if (redirect_valid) begin
                // A stalled redirect is only latched; it is checked when applied.
                if (stall) begin
                    r_next_addr   <= HOLD_ADDR;
                    r_pend_target <= redirect_target;
                    r_state       <= HOLD_PEND;
                end else if (w_redir_ok) begin
                    r_next_addr <= redirect_target;
                    r_state     <= RUN;
                end else begin
                    r_next_addr   <= TRAP_VEC;
                    r_epc         <= cur_addr;
                    r_fault       <= 1'b1;
                    r_fault_cause <= w_redir_cause;
                    r_state       <= RUN;
                end
            end else if (r_state == HOLD_PEND && !stall) begin
                if (w_pend_ok) begin
                    r_next_addr <= r_pend_target;
                end else begin
                    r_next_addr   <= TRAP_VEC;
                    r_epc         <= cur_addr;
                    r_fault       <= 1'b1;
                    r_fault_cause <= w_pend_cause;
                end
                r_state <= RUN;
            end else if (stall) begin
                r_next_addr <= HOLD_ADDR;
                if (r_state != HOLD_PEND) begin
                    r_state <= HOLD;
                end
            end else if (w_wrap) begin
                r_next_addr   <= TRAP_VEC;
                r_epc         <= cur_addr;
                r_fault       <= 1'b1;
                r_fault_cause <= CAUSE_WRAP;
                r_state       <= RUN;
            end else begin
                r_next_addr <= w_seq_addr;
                r_state     <= RUN;
            end
        end
    end

    assign next_addr   = r_next_addr;
    assign epc         = r_epc;
    assign pend_valid  = (r_state == HOLD_PEND);
    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;

endmodule

// File: tb/tb_next_pc.sv
// Directed and randomized checks of next_pc against a behavioural reference model.
module tb_next_pc;

    localparam logic [31:0] VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cur_addr = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap_req = 1'b0;
    logic        mret_req = 1'b0;
    logic [31:0] next_addr;
    logic [31:0] epc;
    logic        pend_valid;
    logic        fault;
    logic [1:0]  fault_cause;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model state
    logic [31:0] m_next = '0, m_epc = '0, m_pend = '0;
    logic        m_pv = 1'b0, m_fault = 1'b0;
    logic [1:0]  m_cause = 2'd0;

    next_pc #(.TRAP_VEC(VEC)) dut (
        .clk             (clk),
        .rst             (rst),
        .cur_addr        (cur_addr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .mret_req        (mret_req),
        .next_addr       (next_addr),
        .epc             (epc),
        .pend_valid      (pend_valid),
        .fault           (fault),
        .fault_cause     (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Illegal-target classification: 0 = legal, otherwise the fault cause.
    function automatic int unsigned bad_kind(input logic [31:0] t);
        if (t % 4 != 0) return 1;
        if (t == 0)     return 2;
        return 0;
    endfunction

    task automatic model_fault(input int unsigned kind, input logic [31:0] cur);
        m_next  = VEC;
        m_epc   = cur;
        m_fault = 1'b1;
        m_cause = 2'(kind);
        m_pv    = 1'b0;
    endtask

    task automatic model_step(input logic r, t, m, rv, st, input logic [31:0] tgt, cur);
        m_fault = 1'b0;
        if (r) begin
            m_next = 0; m_epc = 0; m_pend = 0; m_pv = 0; m_cause = 0;
        end else if (t) begin
            m_next = VEC; m_epc = cur; m_pv = 0;
        end else if (m) begin
            m_next = m_epc; m_pv = 0;
        end else if (rv && st) begin
            m_next = 0; m_pend = tgt; m_pv = 1;
        end else if (rv) begin
            if (bad_kind(tgt) != 0) model_fault(bad_kind(tgt), cur);
            else begin m_next = tgt; m_pv = 0; end
        end else if (m_pv && !st) begin
            if (bad_kind(m_pend) != 0) model_fault(bad_kind(m_pend), cur);
            else begin m_next = m_pend; m_pv = 0; end
        end else if (st) begin
            m_next = 0;
        end else if (64'(cur) + 64'd4 == 64'h1_0000_0000) begin
            model_fault(3, cur);
        end else begin
            m_next = cur + 4;
        end
    endtask

    task automatic step(input logic r, t, m, rv, st, input logic [31:0] tgt, cur);
        @(negedge clk);
        rst = r; trap_req = t; mret_req = m; redirect_valid = rv;
        stall = st; redirect_target = tgt; cur_addr = cur;
        @(posedge clk);
        model_step(r, t, m, rv, st, tgt, cur);
        #1;
        chk("next_addr", next_addr, m_next);
        chk("epc", epc, m_epc);
        chk("pend_valid", 32'(pend_valid), 32'(m_pv));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_cause", 32'(fault_cause), 32'(m_cause));
    endtask

    initial begin
        logic [31:0] cur, tgt;
        logic r, t, m, rv, st;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_next", next_addr, 32'h0);
        chk("rst_cause", 32'(fault_cause), 32'h0);

        // Sequential
        step(0, 0, 0, 0, 0, 0, 32'h0);
        chk("seq_0", next_addr, 32'h4);
        step(0, 0, 0, 0, 0, 0, 32'h4);
        chk("seq_4", next_addr, 32'h8);

        // Stall three cycles with a redirect latched in the second
        step(0, 0, 0, 0, 1, 0, 32'h8);
        chk("stall_c1", next_addr, 32'h0);
        step(0, 0, 0, 1, 1, 32'h200, 32'h8);
        chk("stall_c2", next_addr, 32'h0);
        chk("pend_rise", 32'(pend_valid), 32'h1);
        step(0, 0, 0, 0, 1, 0, 32'h8);
        chk("stall_c3", next_addr, 32'h0);
        chk("pend_hold", 32'(pend_valid), 32'h1);
        step(0, 0, 0, 0, 0, 0, 32'h8);
        chk("pend_apply", next_addr, 32'h200);
        chk("pend_fall", 32'(pend_valid), 32'h0);

        // Trap and return
        step(0, 1, 0, 0, 0, 0, 32'h40);
        chk("trap_next", next_addr, 32'h100);
        chk("trap_epc", epc, 32'h40);
        step(0, 0, 1, 0, 0, 0, 32'h100);
        chk("mret_next", next_addr, 32'h40);

        // Illegal targets
        step(0, 0, 0, 1, 0, 32'h202, 32'h40);
        chk("mis_fault", 32'(fault), 32'h1);
        chk("mis_cause", 32'(fault_cause), 32'h1);
        chk("mis_next", next_addr, 32'h100);
        step(0, 0, 0, 0, 0, 0, 32'h100);
        chk("fault_pulse", 32'(fault), 32'h0);
        chk("cause_kept", 32'(fault_cause), 32'h1);
        step(0, 0, 0, 1, 0, 32'h0, 32'h104);
        chk("zero_cause", 32'(fault_cause), 32'h2);

        // Sequential wrap
        step(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        chk("wrap_cause", 32'(fault_cause), 32'h3);
        chk("wrap_next", next_addr, 32'h100);
        chk("wrap_epc", epc, 32'hFFFF_FFFC);

        // Trap beats redirect and stall, and clears a pending redirect
        step(0, 0, 0, 1, 1, 32'h300, 32'h100);
        step(0, 1, 0, 1, 1, 32'h500, 32'h80);
        chk("simul_next", next_addr, 32'h100);
        chk("simul_pend", 32'(pend_valid), 32'h0);
        chk("simul_epc", epc, 32'h80);

        // Reset during HOLD_PEND, then mret with no trap since reset
        step(0, 0, 0, 1, 1, 32'h400, 32'h100);
        step(1, 0, 0, 0, 1, 0, 32'h100);
        chk("rst_pend", 32'(pend_valid), 32'h0);
        chk("rst_epc", epc, 32'h0);
        step(0, 0, 1, 0, 0, 0, 32'h100);
        chk("mret_epc0", next_addr, 32'h0);
        chk("mret_nofault", 32'(fault), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       cur = 32'hFFFF_FFFC;
                1, 2:    cur = next_addr;
                default: cur = $urandom & 32'h0000_FFFC;
            endcase
            case ($urandom_range(0, 15))
                0:       tgt = 32'h0;
                1, 2:    tgt = ($urandom & 32'h0000_FFFF) | 32'h1;
                default: tgt = ($urandom & 32'h0000_FFFC) | 32'h4;
            endcase
            r  = ($urandom_range(0, 99) == 0);
            t  = ($urandom_range(0, 19) == 0);
            m  = ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 2) == 0);
            step(r, t, m, rv, st, tgt, cur);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
